uart_rx: RTL and testbench

Serial receiver for the console UART, the receive-side counterpart to the transmitter. Oversamples the asynchronous `rx` line on the system clock, recovers 8N1 frames (one start bit, 8 data bits LSB-first, one stop bit), and presents bytes to the CPU bus through a receive buffer with `valid`/`re` handshake plus sticky framing- and overrun-error flags.

---
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// CPU-side bundle of the console UART receiver: serial line in, receive buffer
// head and sticky error flags out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rdata;
  logic       valid;
  logic       re;
  logic       clr_err;
  logic       frame_err;
  logic       overrun;

  modport master (output rx, re, clr_err, input rdata, valid, frame_err, overrun);
  modport slave  (input rx, re, clr_err, output rdata, valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// 8N1 console UART receiver with oversampling bit recovery and a receive buffer.
// UART_RX_FIFO_EN selects a 4-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int unsigned BIT_CYCLES = 434
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam logic [15:0] HALF_M1 = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        push, ferr_set, ovr_set, pop, valid;
  logic        fe_q, fe_d, ovr_q, ovr_d;

  // Synchronizer resets to idle-high so a released reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus.rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      sh_q    <= '0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else if (!rx_s) begin
          state_d = S_DATA;
          cnt_d   = BIT_M1;
          bitn_d  = 3'd0;
        end else state_d = S_IDLE;
      end
      S_DATA: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = BIT_M1;
          if (bitn_q == 3'd7) state_d = S_STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else if (rx_s) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic [3:0][7:0] mem_q;
  logic [1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]      count_q, count_d;
  logic            full, wr;

  assign valid = (count_q != 3'd0);
  assign full  = (count_q == 3'd4);
  assign pop   = bus.re && valid;
  // When full, a same-cycle pop frees the head slot the write pointer points at.
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign wptr_d  = wptr_q + {1'b0, wr};
  assign rptr_d  = rptr_q + {1'b0, pop};
  assign count_d = count_q + {2'b0, wr} - {2'b0, pop};

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) mem_q[wptr_q] <= sh_q;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign bus.rdata = valid ? mem_q[rptr_q] : 8'h00;
`else
  logic [7:0] hold_q, hold_d;
  logic       hv_q, hv_d, wr;

  assign valid   = hv_q;
  assign pop     = bus.re && valid;
  assign wr      = push && (!hv_q || pop);
  assign ovr_set = push && hv_q && !pop;
  assign hold_d  = wr ? sh_q : hold_q;
  assign hv_d    = wr ? 1'b1 : (pop ? 1'b0 : hv_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
      hv_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
    end
  end

  assign bus.rdata = valid ? hold_q : 8'h00;
`endif

  // Sticky flags: a new error event outranks a same-cycle clear.
  assign fe_d  = ferr_set | (fe_q  & ~bus.clr_err);
  assign ovr_d = ovr_set  | (ovr_q & ~bus.clr_err);

  assign bus.valid     = valid;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: serial frames are generated at bit level
// and received bytes are checked against a queue model of the receive buffer.
module tb_uart_rx;
  localparam int B = 8;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr;

  uart_rx_if bus();
  uart_rx #(.BIT_CYCLES(B)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic chk_head(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
    chk({tag, "_rdata"}, {24'd0, bus.rdata}, {24'd0, exp_q[0]});
  endtask

  task automatic pop_chk(input string tag);
    chk_head(tag);
    bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    void'(exp_q.pop_front());
    chk({tag, "_vafter"}, {31'd0, bus.valid}, {31'd0, exp_q.size() != 0});
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ferr"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_ovr"},  {31'd0, bus.overrun},   {31'd0, exp_ovr});
  endtask

  // mode 0: plain frame; 1: pop head during start bit; 2: pop head in the push cycle
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    bus.rx = 1'b0;
    if (mode == 1) begin
      pop_chk("pop_start");
      repeat (B - 1) tick();
    end else repeat (B) tick();
    for (int k = 0; k < 8; k++) begin
      bus.rx = b[k];
      repeat (B) tick();
    end
    bus.rx = stop;
    if (mode == 2) begin
      repeat (B - 2) tick();
      chk_head("pop_push");
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      void'(exp_q.pop_front());
      tick();
    end else repeat (B) tick();
    if (stop) model_push(b);
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] fb;
    exp_ovr     = 1'b0;
    reset       = 1'b0;
    bus.rx      = 1'b1;
    bus.re      = 1'b0;
    bus.clr_err = 1'b0;
    repeat (4) tick();
    chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk_flags("rst");
    reset = 1'b1;
    repeat (4) tick();

    // two back-to-back frames, first popped during the second's start bit
    send_frame(8'h55, 1'b1, 0);
    chk_head("f55");
    send_frame(8'hA3, 1'b1, 1);
    repeat (2) tick();
    pop_chk("fA3");
    chk_flags("b2b");

    // short low glitch must be rejected silently
    bus.rx = 1'b0;
    repeat (3) tick();
    bus.rx = 1'b1;
    repeat (20) tick();
    chk("glitch_valid", {31'd0, bus.valid}, 32'd0);
    chk_flags("glitch");

    // bad stop bit followed by a held-low line: one framing error, no byte
    send_frame(8'h3C, 1'b0, 0);
    repeat (10) tick();
    chk("brk_ferr", {31'd0, bus.frame_err}, 32'd1);
    chk("brk_valid", {31'd0, bus.valid}, 32'd0);
    clear_err();
    repeat (30) tick();
    chk("brk_ferr_once", {31'd0, bus.frame_err}, 32'd0);
    bus.rx = 1'b1;
    repeat (10) tick();
    send_frame(8'h7E, 1'b1, 0);
    repeat (2) tick();
    pop_chk("f7E");
    chk_flags("f7E");

    // overrun: one more frame than the buffer holds, no reads
    for (int i = 0; i <= DEPTH; i++) send_frame(8'($urandom), 1'b1, 0);
    repeat (2) tick();
    chk("ovr_set", {31'd0, bus.overrun}, {31'd0, exp_ovr});
    while (exp_q.size() != 0) pop_chk("ovr_drain");
    clear_err();
    chk_flags("ovr_clr");

    // buffer full, pop lands exactly on the push cycle
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 0);
    send_frame(8'($urandom), 1'b1, 2);
    repeat (2) tick();
    chk_flags("poppush");
    while (exp_q.size() != 0) pop_chk("poppush_drain");

    // randomized back-to-back stream
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom);
      send_frame(r, 1'b1, (exp_q.size() != 0) ? 1 : 0);
    end
    repeat (2) tick();
    while (exp_q.size() != 0) pop_chk("rnd_drain");
    chk_flags("rnd");

    // reset in the middle of a frame with state pending
    send_frame(8'h11, 1'b0, 0);
    bus.rx = 1'b1;
    repeat (12) tick();
    send_frame(8'h42, 1'b1, 0);
    fb = 8'hE5;
    bus.rx = 1'b0;
    repeat (B) tick();
    for (int k = 0; k < 4; k++) begin
      bus.rx = fb[k];
      repeat (B) tick();
    end
    bus.rx = fb[4];
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    bus.rx = fb[5];
    repeat (2) tick();
    exp_q.delete();
    exp_ovr = 1'b0;
    chk("mrst_rdata", {24'd0, bus.rdata}, 32'd0);
    chk("mrst_valid", {31'd0, bus.valid}, 32'd0);
    chk_flags("mrst");
    reset = 1'b1;
    repeat (B - 2) tick();
    for (int k = 6; k < 8; k++) begin
      bus.rx = fb[k];
      repeat (B) tick();
    end
    bus.rx = 1'b1;
    repeat (B + 20) tick();
    chk("mrst_novalid", {31'd0, bus.valid}, 32'd0);
    send_frame(8'h81, 1'b1, 0);
    repeat (2) tick();
    pop_chk("f81");
    chk_flags("f81");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
